// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin decoder arbiter.
// The master side issues requests; the arbiter (slave) returns decoder controls and grants.
interface rr_decoder_arbiter_if;
    logic [3:0] req;
    logic       address0;
    logic       address1;
    logic       enable;
    logic [3:0] grant;
    logic       busy;

    modport master (output req, input address0, address1, enable, grant, busy);
    modport slave  (input req, output address0, address1, enable, grant, busy);
endinterface

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder: registered address/enable plus matching one-hot grant.
// Owner holds until release, with optional forced hand-off after MAX_HOLD cycles of contention.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rr_decoder_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state_p0, state_nxt;
    logic [1:0]       owner_p0, owner_nxt;
    logic [1:0]       last_p0, last_nxt;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;
    logic             en_p0, en_nxt;
    logic [3:0]       grant_p0, grant_nxt;
    logic [3:0]       others;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_hand;

    // Returns {found, index} of the first asserted request after 'start', wrapping 3->0.
    function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] r);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

    always_comb begin
        state_nxt = state_p0;
        owner_nxt = owner_p0;
        last_nxt  = last_p0;
        cnt_nxt   = cnt_p0;
        others    = bus.req & ~(4'b0001 << owner_p0);
        pick_idle = rr_pick(last_p0, bus.req);
        pick_hand = rr_pick(owner_p0, others);
        case (state_p0)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nxt = OWNED;
                    owner_nxt = pick_idle[1:0];
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWNED: begin
                // Release takes precedence over preemption; the owner's bit is already clear here.
                if (!bus.req[owner_p0]) begin
                    last_nxt = owner_p0;
                    if (pick_hand[2]) begin
                        owner_nxt = pick_hand[1:0];
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (MAX_HOLD != 0 && cnt_p0 == HOLD_LIM && pick_hand[2]) begin
                    last_nxt  = owner_p0;
                    owner_nxt = pick_hand[1:0];
                    cnt_nxt   = CNT_ONE;
                end else if (MAX_HOLD != 0 && cnt_p0 != HOLD_LIM) begin
                    cnt_nxt = cnt_p0 + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        en_nxt    = (state_nxt == OWNED);
        grant_nxt = en_nxt ? (4'b0001 << owner_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_p0 <= IDLE;
            owner_p0 <= 2'd0;
            last_p0  <= 2'd3;
            cnt_p0   <= '0;
            en_p0    <= 1'b0;
            grant_p0 <= 4'b0000;
        end else begin
            state_p0 <= state_nxt;
            owner_p0 <= owner_nxt;
            last_p0  <= last_nxt;
            cnt_p0   <= cnt_nxt;
            en_p0    <= en_nxt;
            grant_p0 <= grant_nxt;
        end
    end

    assign bus.address0 = owner_p0[0];
    assign bus.address1 = owner_p0[1];
    assign bus.enable   = en_p0;
    assign bus.busy     = en_p0;
    assign bus.grant    = grant_p0;

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
Round-robin arbiter that shares one 2-to-4 decoder-selected resource among four requesters. It samples a 4-bit request vector and produces registered decoder controls (address0, address1, enable) plus the matching one-hot grant vector. The {address1,address0,enable} outputs connect directly to the address/enable inputs of the existing 2-to-4 decoder. A grant is held until its owner releases it, with optional forced hand-off after MAX_HOLD cycles when others are waiting.

Parameters:
MAX_HOLD, 8, max consecutive cycles one owner keeps the grant while another request is pending; 0 = no preemption (hold until release)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
req  input  4  request vector; req[i] high = requester i wants the resource
address0  output  1  decoder address bit 0 (LSB of owner index)
address1  output  1  decoder address bit 1 (MSB of owner index)
enable  output  1  decoder enable; high when a grant is active
grant  output  4  one-hot grant; grant[i] = enable & ({address1,address0}==i)
busy  output  1  high in OWNED state (equals enable)

Behaviour:
- Clock/reset: one clock domain (clk); reset is synchronous, active-low (reset_n); all outputs registered.
- Reset (reset_n=0 at an edge): state=IDLE, enable=0, address1/address0=00, grant=0000, busy=0, last_owner=3 (requester 0 wins first), hold_cnt=0. Applies mid-grant: grant drops at that edge, no hand-off.
- Round-robin search: candidates checked in order last_owner+1, +2, +3, +4 (mod 4); first asserted req wins. Index wrap 3->0.
- IDLE: if req==0000 stay IDLE, outputs unchanged (enable=0, address holds last value). If any req at edge N: after edge N enable=1, address=winner, grant one-hot, state=OWNED, hold_cnt=1. Latency req->grant: 1 cycle.
- OWNED, owner o, checked each edge in priority order:
  1. req[o]=0 (release): last_owner=o. If other req pending, grant goes directly to RR winner starting at o+1 (no idle cycle), hold_cnt=1. Else state=IDLE, enable=0, grant=0000, address holds o.
  2. MAX_HOLD!=0, hold_cnt==MAX_HOLD, and any req[j], j!=o, asserted: preempt; last_owner=o; grant to RR winner among j!=o starting at o+1; hold_cnt=1.
  3. Otherwise keep grant; hold_cnt increments, saturating at MAX_HOLD (counter stays at MAX_HOLD while owner alone; preemption fires on first edge another request appears).
- MAX_HOLD=0: hold_cnt is ignored; the owner keeps the grant until it releases.
- hold_cnt width = clog2(MAX_HOLD+1), min 1 bit; no overflow.
- Invariants: grant never multi-hot; grant==0000 iff enable==0; busy==enable; a new owner always comes from a req asserted at the deciding edge.
- Simultaneous release + other reqs: the release path (rule 1) applies, not preemption.
- Requests that drop before being granted are forgotten (no queueing).

Test Plan:
- Reset: reset_n=0 for 2 cycles with req=1111 -> enable=0, grant=0000, address=00 throughout; release reset_n with req=1111 -> 1 cycle later grant=0001, address=00, enable=1.
- Fairness: req=1111 held, each owner drops req for 1 cycle after grant then reasserts, MAX_HOLD=0 -> grant sequence 0001,0010,0100,1000,0001 (wrap), no idle cycles between owners.
- Hand-off skip: owner 1 releases, req=1001 -> next grant=1000 (index 3 before 0); then release with req=0000 -> enable=0, grant=0000, address stays 11.
- Preemption: MAX_HOLD=4, req=0001 held, req[2] asserted at cycle 10 after grant -> grant moves to 0100 on that edge; with req[2] asserted from grant start -> grant 0001 for exactly 4 cycles, then 0100.
- Mid-grant reset: owner 2 active, reset_n=0 for 1 edge -> enable=0 that edge; after release with req=0110 -> grant=0010 (last_owner reset to 3).
- Decoder check: instantiate with 2-to-4 decoder on address0/address1/enable; random req for 1000 cycles -> decoder outputs equal grant after decoder delay, never multi-hot.
